// File: rtl/sram_pkg.sv
// Shared definitions for the byte-enable SRAM controller: FSM states, lane count, read latency.
// Read latency follows SRAM_RD_REG_EN (1 cycle default, 2 with the output register stage).
package sram_pkg;
   typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_e;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   localparam int DW_DEF = 32;
   localparam int NB     = DW_DEF / 8;

`ifdef SRAM_RD_REG_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/sram_clear_seq.sv
// Clear sequencer: walks every word once after reset, then holds RUN until the next reset.
// ready comes straight from the state register, so it never depends on client inputs.
module sram_clear_seq
   import sram_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   output logic          ready,
   output logic          clr_we,
   output logic [PW-1:0] clr_addr
);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [0:0]    state;
   logic [PW-1:0] ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
         ptr   <= '0;
      end else if (state == ST_CLEAR) begin
         ptr <= ptr + PW'(1);
         if (ptr == LAST) state <= ST_RUN;
      end
   end

   assign ready    = (state == ST_RUN);
   assign clr_we   = (state == ST_CLEAR);
   assign clr_addr = ptr;
endmodule

// File: rtl/sram_be_ctrl.sv
// Single-port SRAM with per-byte write enables, read-valid strobe and clear-after-reset.
// Optional SRAM_RD_REG_EN adds an output register stage (read latency 2, same throughput).
module sram_be_ctrl
   import sram_pkg::*;
#(
   parameter int            DW       = 32,
   parameter int            AW       = 16,
   parameter int            DEPTH    = 65536,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   di,
   input  logic            en,
   input  logic            we,
   input  logic [DW/8-1:0] be,
   output logic            ready,
   output logic [DW-1:0]   rdata,
   output logic            rvalid
);
   localparam int             LANES   = DW / 8;
   localparam int             IW      = idx_w(DEPTH);
   localparam logic [AW:0]    DEPTH_W = (AW + 1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic          clr_we;
   logic [IW-1:0] clr_addr;
   logic [IW-1:0] idx;
   logic          in_range;
   logic          accept;
   logic          wr;
   logic          rd;

   sram_clear_seq #(.DEPTH(DEPTH), .PW(IW)) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign in_range = ({1'b0, addr} < DEPTH_W);
   assign idx      = addr[IW-1:0];
   assign accept   = en && ready && !rst;
   assign wr       = accept && we && in_range;
   assign rd       = accept && !we;

   // Clear and client writes are exclusive by state; out-of-range writes never reach the array.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
         end else if (wr) begin
            for (int k = 0; k < LANES; k++) begin
               if (be[k]) mem[idx][8*k +: 8] <= di[8*k +: 8];
            end
         end
      end
   end

   logic          rv1;
   logic [DW-1:0] rd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         rv1 <= 1'b0;
         rd1 <= '0;
      end else begin
         rv1 <= rd;
         if (rd) rd1 <= in_range ? mem[idx] : '0;
      end
   end

`ifdef SRAM_RD_REG_EN
   logic          rv2;
   logic [DW-1:0] rd2;

   always_ff @(posedge clk) begin
      if (rst) begin
         rv2 <= 1'b0;
         rd2 <= '0;
      end else begin
         rv2 <= rv1;
         if (rv1) rd2 <= rd1;
      end
   end

   assign rvalid = rv2;
   assign rdata  = rd2;
`else
   assign rvalid = rv1;
   assign rdata  = rd1;
`endif
endmodule

// File: tb/tb_sram_be_ctrl.sv
// Bench for sram_be_ctrl (DW=32, AW=16, DEPTH=16): vector table, corner sequences, random traffic.
module tb_sram_be_ctrl;
   import sram_pkg::*;

   localparam int          DW    = 32;
   localparam int          AW    = 16;
   localparam int          DEPTH = 16;
   localparam logic [31:0] INIT  = 32'hDEADBEEF;

   logic          clk  = 1'b0;
   logic          rst  = 1'b1;
   logic          en   = 1'b0;
   logic          we   = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] di   = '0;
   logic [3:0]    be   = '0;
   logic          ready;
   logic          rvalid;
   logic [DW-1:0] rdata;

   int checks = 0;
   int errors = 0;

   sram_be_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .INIT_VAL(INIT)) dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .di     (di),
      .en     (en),
      .we     (we),
      .be     (be),
      .ready  (ready),
      .rdata  (rdata),
      .rvalid (rvalid)
   );

   always #5 clk = ~clk;

   // Reference model: memory contents, cycles since reset, and a read-result delay line.
   logic [31:0] mmem [DEPTH];
   int          cnt    = 0;
   bit          mready = 1'b0;
   bit          pv [RD_LAT];
   logic [31:0] pd [RD_LAT];
   bit          exp_rv = 1'b0;
   logic [31:0] exp_rd = '0;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] di;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;
   vec_t tab [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input bit use_exp, input logic [31:0] xe);
      bit          acc;
      bit          nv;
      logic [31:0] nd;
      rst = r; en = e; we = w; addr = a; di = d; be = b;
      acc = !r && e && mready;
      nv  = acc && !w;
      nd  = '0;
      if (nv) nd = use_exp ? xe : ((a < DEPTH) ? mmem[a] : 32'h0);
      if (acc && w && a < DEPTH) begin
         for (int k = 0; k < 4; k++) if (b[k]) mmem[a][8*k +: 8] = d[8*k +: 8];
      end
      @(posedge clk);
      #1;
      if (r) begin
         cnt = 0;
         mready = 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
         for (int i = 0; i < DEPTH; i++) mmem[i] = INIT;
         exp_rv = 1'b0;
         exp_rd = '0;
      end else begin
         if (cnt < DEPTH) cnt++;
         mready = (cnt >= DEPTH);
         for (int i = RD_LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
         pv[0] = nv;
         pd[0] = nd;
         exp_rv = pv[RD_LAT-1];
         if (exp_rv) exp_rd = pd[RD_LAT-1];
      end
      chk("ready", {31'b0, ready}, {31'b0, mready});
      chk("rvalid", {31'b0, rvalid}, {31'b0, exp_rv});
      chk("rdata", rdata, exp_rd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 4'd0, 1'b0, 32'd0);
   endtask

   task automatic wait_clear(input int start, input string name);
      int n;
      n = start;
      while (!ready && n < 40) begin
         idle(1);
         n++;
      end
      chk(name, n, DEPTH);
   endtask

   initial begin
      tab[0]  = '{1'b1, 16'd3,  32'h11223344, 4'hF,    32'h0};
      tab[1]  = '{1'b1, 16'd3,  32'hAABBCCDD, 4'b0101, 32'h0};
      tab[2]  = '{1'b0, 16'd3,  32'h0,        4'h0,    32'h11BB33DD};
      tab[3]  = '{1'b1, 16'd20, 32'h00000005, 4'hF,    32'h0};
      tab[4]  = '{1'b0, 16'd20, 32'h0,        4'hF,    32'h00000000};
      tab[5]  = '{1'b0, 16'd4,  32'h0,        4'h0,    INIT};
      tab[6]  = '{1'b1, 16'd4,  32'h0,        4'h0,    32'h0};
      tab[7]  = '{1'b0, 16'd4,  32'h0,        4'h0,    INIT};
      tab[8]  = '{1'b1, 16'd15, 32'hCAFEF00D, 4'hF,    32'h0};
      tab[9]  = '{1'b0, 16'd15, 32'h0,        4'h0,    32'hCAFEF00D};
      tab[10] = '{1'b0, 16'd0,  32'h0,        4'h0,    INIT};
      tab[11] = '{1'b0, 16'd3,  32'h0,        4'h0,    32'h11BB33DD};
      tab[12] = '{1'b1, 16'd7,  32'h12345678, 4'b1000, 32'h0};
      tab[13] = '{1'b0, 16'd7,  32'h0,        4'h0,    32'h12ADBEEF};
      for (int i = 0; i < RD_LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
      for (int i = 0; i < DEPTH; i++) mmem[i] = INIT;

      // Reset, then a write attempt while the clear is still running.
      step(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 4'd0, 1'b0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, 4'd0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b1, 16'd0, 32'd5, 4'hF, 1'b0, 32'd0);
      wait_clear(1, "clear_len");

      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 1'b1, 1'b0, 16'(i), 32'd0, 4'hF, 1'b1, INIT);
      idle(RD_LAT);

      for (int i = 0; i < 14; i++)
         step(1'b0, 1'b1, tab[i].we, tab[i].addr, tab[i].di, tab[i].be, !tab[i].we, tab[i].exp);
      idle(RD_LAT);

      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 1'b1, 16'(i), 32'(i), 4'hF, 1'b0, 32'd0);
         step(1'b0, 1'b1, 1'b0, 16'(i), 32'd0, 4'h0, 1'b1, 32'(i));
      end
      idle(RD_LAT);

      for (int i = 0; i < 400; i++)
         step(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              16'($urandom_range(0, 23)), $urandom, 4'($urandom_range(0, 15)), 1'b0, 32'd0);
      idle(RD_LAT);

      // Read accepted, then reset on the next edge; a read presented on the reset edge too.
      step(1'b0, 1'b1, 1'b0, 16'd5, 32'd0, 4'd0, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 16'd6, 32'd0, 4'd0, 1'b0, 32'd0);
      wait_clear(0, "reclear_len");
      step(1'b0, 1'b1, 1'b0, 16'd3, 32'd0, 4'd0, 1'b1, INIT);
      idle(RD_LAT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
